dotp_stream_acc: RTL and testbench

- Parametrised, fully pipelined streaming dot-product engine; successor to the single-beat multiply/add-tree.
- Each accepted beat carries N packed K-bit elements per operand. Lanes are multiplied, reduced through a registered adder tree, and accumulated across beats until a `last` beat.
- Sits between operand buffers and the result writeback in the matrix datapath. Uses valid/ready handshakes on both sides with full backpressure.

---
 rtl/dotp_stream_acc.sv | 217 +++++++++++++++++++++
 tb/tb_dotp_stream_acc.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dotp_stream_acc.sv
// dotp_stream_acc: pipelined streaming dot-product engine with multi-beat accumulation.
// Define DOTP_SIGNED_EN for two's-complement elements and signed-overflow flagging.
module dotp_stream_acc #(
    parameter int K  = 8,
    parameter int N  = 4,
    parameter int G  = 8,
    parameter int CW = 8,
    localparam int D  = $clog2(N),
    localparam int OW = 2*K + D + G
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [K*N-1:0] in_a,
    input  logic [K*N-1:0] in_b,
    input  logic           in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OW-1:0]  out_data,
    output logic [CW-1:0]  out_beats,
    output logic           out_ovf
);

`ifdef DOTP_SIGNED_EN
    localparam logic SGN = 1'b1;
`else
    localparam logic SGN = 1'b0;
`endif

    localparam int PW = 2*K;
    localparam int TW = PW + D;

    logic           in_vld_d, in_vld_q, in_last_d, in_last_q;
    logic [K*N-1:0] in_a_d, in_a_q, in_b_d, in_b_q;

    logic [TW-1:0]  tree_sum;
    logic [OW-1:0]  tree_ext;
    logic           tree_vld, tree_last;

    logic [OW-1:0]  acc_d, acc_q, out_data_d, out_data_q, base, acc_sum;
    logic [CW-1:0]  cnt_d, cnt_q, cnt_inc, out_beats_d, out_beats_q;
    logic           first_d, first_q, ovf_d, ovf_q, out_ovf_d, out_ovf_q;
    logic           out_valid_d, out_valid_q;
    logic           acc_wrap, cnt_wrap, ovf_any;
    logic           en;

    // A held result with no taker freezes every stage at once.
    assign en       = !(out_valid_q && !out_ready);
    assign in_ready = en;

    always_comb begin
        in_vld_d  = in_vld_q;
        in_last_d = in_last_q;
        in_a_d    = in_a_q;
        in_b_d    = in_b_q;
        if (en) begin
            in_vld_d  = in_valid;
            in_last_d = in_last;
            in_a_d    = in_a;
            in_b_d    = in_b;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_vld_q  <= 1'b0;
            in_last_q <= 1'b0;
            in_a_q    <= '0;
            in_b_q    <= '0;
        end else begin
            in_vld_q  <= in_vld_d;
            in_last_q <= in_last_d;
            in_a_q    <= in_a_d;
            in_b_q    <= in_b_d;
        end
    end

    // Level 0 holds the lane products; level l halves the operand count and widens by one bit.
    for (genvar l = 0; l <= D; l++) begin : g_lvl
        localparam int CNT = (N + (1 << l) - 1) >> l;
        localparam int W   = PW + l;

        logic [CNT-1:0][W-1:0] sum_d, sum_q;
        logic                  vld_d, vld_q, last_d, last_q;

        if (l == 0) begin : g_prod
            always_comb begin
                sum_d  = sum_q;
                vld_d  = vld_q;
                last_d = last_q;
                if (en) begin
                    vld_d  = in_vld_q;
                    last_d = in_last_q;
                    for (int i = 0; i < N; i++) begin
                        sum_d[i] = {{K{SGN & in_a_q[K*i+K-1]}}, in_a_q[K*i +: K]}
                                 * {{K{SGN & in_b_q[K*i+K-1]}}, in_b_q[K*i +: K]};
                    end
                end
            end
        end else begin : g_tree
            localparam int PCNT = (N + (1 << (l-1)) - 1) >> (l-1);

            logic [PCNT-1:0][W-2:0] prev;
            assign prev = g_lvl[l-1].sum_q;

            always_comb begin
                sum_d  = sum_q;
                vld_d  = vld_q;
                last_d = last_q;
                if (en) begin
                    vld_d  = g_lvl[l-1].vld_q;
                    last_d = g_lvl[l-1].last_q;
                    for (int j = 0; j < CNT; j++) begin
                        if (2*j + 1 < PCNT) begin
                            sum_d[j] = {SGN & prev[2*j][W-2], prev[2*j]}
                                     + {SGN & prev[(2*j+1 < PCNT) ? 2*j+1 : 2*j][W-2],
                                        prev[(2*j+1 < PCNT) ? 2*j+1 : 2*j]};
                        end else begin
                            sum_d[j] = {SGN & prev[2*j][W-2], prev[2*j]};
                        end
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sum_q  <= '0;
                vld_q  <= 1'b0;
                last_q <= 1'b0;
            end else begin
                sum_q  <= sum_d;
                vld_q  <= vld_d;
                last_q <= last_d;
            end
        end
    end

    assign tree_sum  = g_lvl[D].sum_q[0];
    assign tree_vld  = g_lvl[D].vld_q;
    assign tree_last = g_lvl[D].last_q;

`ifdef DOTP_SIGNED_EN
    assign tree_ext = OW'($signed(tree_sum));
`else
    assign tree_ext = OW'(tree_sum);
`endif

    always_comb begin
        base = first_q ? '0 : acc_q;
`ifdef DOTP_SIGNED_EN
        acc_sum  = base + tree_ext;
        acc_wrap = (base[OW-1] == tree_ext[OW-1]) && (acc_sum[OW-1] != base[OW-1]);
`else
        {acc_wrap, acc_sum} = {1'b0, base} + {1'b0, tree_ext};
`endif
        cnt_wrap = !first_q && (cnt_q == '1);
        cnt_inc  = first_q ? CW'(1) : cnt_q + CW'(1);
        ovf_any  = ovf_q | acc_wrap | cnt_wrap;
    end

    // A completing vector may replace a result in the same cycle it is consumed.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        ovf_d       = ovf_q;
        out_data_d  = out_data_q;
        out_beats_d = out_beats_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q && !out_ready;
        if (tree_vld && en) begin
            if (tree_last) begin
                out_data_d  = acc_sum;
                out_beats_d = cnt_inc;
                out_ovf_d   = ovf_any;
                out_valid_d = 1'b1;
                first_d     = 1'b1;
                ovf_d       = 1'b0;
            end else begin
                acc_d   = acc_sum;
                cnt_d   = cnt_inc;
                ovf_d   = ovf_any;
                first_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            first_q     <= 1'b1;
            ovf_q       <= 1'b0;
            out_data_q  <= '0;
            out_beats_q <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            ovf_q       <= ovf_d;
            out_data_q  <= out_data_d;
            out_beats_q <= out_beats_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_beats = out_beats_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_dotp_stream_acc.sv
// Testbench for dotp_stream_acc: a default instance and a CW=2/G=0 instance share one
// input stream; each has its own scoreboard fed by a behavioural accumulation model.
module tb_dotp_stream_acc;

    localparam int K   = 8;
    localparam int N   = 4;
    localparam int D   = 2;
    localparam int OW0 = 26;
    localparam int CW0 = 8;
    localparam int OW1 = 18;
    localparam int CW1 = 2;

    typedef struct {
        logic [63:0] data;
        logic [63:0] beats;
        logic        ovf;
    } exp_t;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic [K*N-1:0] in_a;
    logic [K*N-1:0] in_b;
    logic           in_last;
    logic           out_ready;

    logic           in_ready0, out_valid0, out_ovf0;
    logic [OW0-1:0] out_data0;
    logic [CW0-1:0] out_beats0;
    logic           in_ready1, out_valid1, out_ovf1;
    logic [OW1-1:0] out_data1;
    logic [CW1-1:0] out_beats1;

    exp_t   q0[$];
    exp_t   q1[$];
    longint m_acc[2];
    int     m_beats[2];
    bit     m_ovf[2];
    int     n_vec = 0;
    int     n_err = 0;

    localparam logic [31:0] A1 = {8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [31:0] B1 = {8'd8, 8'd7, 8'd6, 8'd5};

    dotp_stream_acc dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_beats(out_beats0), .out_ovf(out_ovf0)
    );

    dotp_stream_acc #(.CW(CW1), .G(0)) dut_w (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_beats(out_beats1), .out_ovf(out_ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic longint beat_dot(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = 0;
        for (int i = 0; i < N; i++) begin
`ifdef DOTP_SIGNED_EN
            s += longint'($signed(a[8*i +: 8])) * longint'($signed(b[8*i +: 8]));
`else
            s += longint'(a[8*i +: 8]) * longint'(b[8*i +: 8]);
`endif
        end
        return s;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_acc[k]   = 0;
            m_beats[k] = 0;
            m_ovf[k]   = 1'b0;
        end
    endtask

    task automatic model_beat(input longint p, input bit last);
        for (int k = 0; k < 2; k++) begin
            exp_t   e;
            longint lim, v;
            int     cw;
            lim = longint'(1) << ((k == 0) ? OW0 : OW1);
            cw  = (k == 0) ? CW0 : CW1;
            v   = m_acc[k] + p;
`ifdef DOTP_SIGNED_EN
            if (v >= lim / 2) begin
                v -= lim;
                m_ovf[k] = 1'b1;
            end else if (v < -(lim / 2)) begin
                v += lim;
                m_ovf[k] = 1'b1;
            end
`else
            if (v >= lim) begin
                v -= lim;
                m_ovf[k] = 1'b1;
            end
`endif
            m_acc[k] = v;
            m_beats[k]++;
            if (m_beats[k] == (1 << cw)) begin
                m_beats[k] = 0;
                m_ovf[k]   = 1'b1;
            end
            if (last) begin
                e.data  = 64'(v & (lim - 1));
                e.beats = 64'(m_beats[k]);
                e.ovf   = m_ovf[k];
                if (k == 0) q0.push_back(e);
                else        q1.push_back(e);
                m_acc[k]   = 0;
                m_beats[k] = 0;
                m_ovf[k]   = 1'b0;
            end
        end
    endtask

    // Offer one beat until accepted; entered and left just after a rising edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit last);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            done = in_ready0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 64'(in_ready0), 64'd1);
        else       model_beat(beat_dot(a, b), last);
    endtask

    task automatic drain();
        for (int c = 0; c < 200 && (q0.size() != 0 || q1.size() != 0); c++) step(1);
        step(3);
        check("drain_q0", 64'(q0.size()), 64'd0);
        check("drain_q1", 64'(q1.size()), 64'd0);
    endtask

    always @(negedge clk) begin : checkOutput
        exp_t e;
        if (rst && out_ready && out_valid0) begin
            if (q0.size() == 0) begin
                check("out0_unexpected", 64'(out_valid0), 64'd0);
            end else begin
                e = q0.pop_front();
                check("out0_data", 64'(out_data0), e.data);
                check("out0_beats", 64'(out_beats0), e.beats);
                check("out0_ovf", 64'(out_ovf0), 64'(e.ovf));
            end
        end
        if (rst && out_ready && out_valid1) begin
            if (q1.size() == 0) begin
                check("out1_unexpected", 64'(out_valid1), 64'd0);
            end else begin
                e = q1.pop_front();
                check("out1_data", 64'(out_data1), e.data);
                check("out1_beats", 64'(out_beats1), e.beats);
                check("out1_ovf", 64'(out_ovf1), 64'(e.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no completion, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int nb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        model_clear();
        #2 rst = 1'b0;

        @(negedge clk);
        check("rst_out_valid", 64'(out_valid0), 64'd0);
        check("rst_out_data", 64'(out_data0), 64'd0);
        check("rst_out_beats", 64'(out_beats0), 64'd0);
        check("rst_out_ovf", 64'(out_ovf0), 64'd0);
        check("rst_in_ready", 64'(in_ready0), 64'd1);
        step(1);
        rst = 1'b1;
        step(1);

        $display("[TB] single beat and latency");
        applyStimulus(A1, B1, 1'b1);
        for (int c = 0; c < D + 2; c++) begin
            @(negedge clk);
            check("lat_not_yet", 64'(out_valid0), 64'd0);
        end
        @(negedge clk);
        check("lat_valid", 64'(out_valid0), 64'd1);
        check("lat_data", 64'(out_data0), 64'd70);
        check("lat_beats", 64'(out_beats0), 64'd1);
        check("lat_ovf", 64'(out_ovf0), 64'd0);
        step(1);
        drain();

        $display("[TB] two-beat vector then all-ones beat");
        applyStimulus(A1, B1, 1'b0);
        applyStimulus(A1, B1, 1'b1);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        drain();

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(A1, B1, 1'b1);
        applyStimulus({8'd12, 8'd11, 8'd10, 8'd9}, 32'h0101_0101, 1'b1);
        applyStimulus(32'h0202_0202, 32'h0303_0303, 1'b1);
        step(3);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready0), 64'd0);
            check("bp_out_valid", 64'(out_valid0), 64'd1);
            check("bp_hold_data", 64'(out_data0), 64'd70);
            step(1);
        end
        out_ready = 1'b1;
        drain();

        $display("[TB] reset mid-vector");
        applyStimulus(A1, B1, 1'b0);
        applyStimulus(A1, B1, 1'b0);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid0), 64'd0);
        check("mid_rst_data", 64'(out_data0), 64'd0);
        check("mid_rst_beats", 64'(out_beats0), 64'd0);
        check("mid_rst_data_w", 64'(out_data1), 64'd0);
        model_clear();
        step(2);
        rst = 1'b1;
        step(1);
        applyStimulus(A1, B1, 1'b1);
        drain();

        $display("[TB] counter and accumulator wrap");
        for (int bt = 0; bt < 5; bt++) applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, bt == 4);
        drain();

        $display("[TB] sign-sensitive operands");
        applyStimulus(32'h8080_8080, 32'h8080_8080, 1'b1);
        applyStimulus(32'hFFFF_FFFF, 32'h0101_0101, 1'b1);
        drain();

        $display("[TB] random vectors with bubbles and stalls");
        for (int v = 0; v < 10; v++) begin
            nb = $urandom_range(1, 4);
            for (int bt = 0; bt < nb; bt++) begin
                if ($urandom_range(0, 3) == 0) step($urandom_range(1, 3));
                if ($urandom_range(0, 4) == 0) begin
                    out_ready = 1'b0;
                    step($urandom_range(1, 4));
                    out_ready = 1'b1;
                end
                applyStimulus($urandom, $urandom, bt == nb - 1);
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
